// File: rtl/hex_scan_display.sv
// Time-multiplexed hex/binary 7-segment scanner with tear-free double-buffered
// loads, leading-zero blanking and PWM brightness within each digit's dwell.
module hex_scan_display #(
  parameter int N_DIGITS = 4,
  parameter int DWELL_W  = 14,
  parameter int BRIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_load,
  input  logic                  i_mode,
  input  logic                  i_blank_lz,
  input  logic [BRIGHT_W-1:0]   i_bright,
  output logic [N_DIGITS-1:0]   o_anodes,
  output logic [7:0]            o_segments,
  output logic                  o_frame
);
  localparam int D_W    = $clog2(N_DIGITS);
  localparam int DATA_W = 4 * N_DIGITS;

  logic [DWELL_W-1:0]           cnt;
  logic [D_W-1:0]               d;
  logic [DATA_W-1:0]            shadow_data, disp_data;
  logic [N_DIGITS-1:0]          shadow_dp, disp_dp;
  logic                         pending;
  logic                         cnt_max, last_digit, frame_wrap;

  assign cnt_max    = &cnt;
  assign last_digit = (d == D_W'(N_DIGITS - 1));
  assign frame_wrap = cnt_max & last_digit;
  assign o_frame    = frame_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      d   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt_max) d <= last_digit ? '0 : d + 1'b1;
    end
  end

  // Display register only changes at frame wrap so a scan never mixes two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
    end else if (i_load && frame_wrap) begin
      disp_data <= i_data;
      disp_dp   <= i_dp;
      pending   <= 1'b0;
    end else if (i_load) begin
      shadow_data <= i_data;
      shadow_dp   <= i_dp;
      pending     <= 1'b1;
    end else if (frame_wrap && pending) begin
      disp_data <= shadow_data;
      disp_dp   <= shadow_dp;
      pending   <= 1'b0;
    end
  end

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 8'hFC;  4'h1: hex_glyph = 8'h60;
      4'h2: hex_glyph = 8'hDA;  4'h3: hex_glyph = 8'hF2;
      4'h4: hex_glyph = 8'h66;  4'h5: hex_glyph = 8'hB6;
      4'h6: hex_glyph = 8'hBE;  4'h7: hex_glyph = 8'hE0;
      4'h8: hex_glyph = 8'hFE;  4'h9: hex_glyph = 8'hF6;
      4'hA: hex_glyph = 8'hEE;  4'hB: hex_glyph = 8'h3E;
      4'hC: hex_glyph = 8'h9C;  4'hD: hex_glyph = 8'h7A;
      4'hE: hex_glyph = 8'h9E;  default: hex_glyph = 8'h8E;
    endcase
  endfunction

  logic [N_DIGITS-1:0][3:0] nibs;
  logic [N_DIGITS-1:0]      upper_zero;
  assign nibs = disp_data;

  // upper_zero[k]: this nibble and every more significant one are zero.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
    assign upper_zero[k] = ~|nibs[N_DIGITS-1:k];
  end

  logic [BRIGHT_W-1:0] level;
  logic                lit, blank;
  logic [7:0]          glyph, seg_next;
  logic [N_DIGITS-1:0] anodes_next;

  always_comb begin
    level = cnt[DWELL_W-1 -: BRIGHT_W];
    lit   = (level <= i_bright);
    blank = i_mode & i_blank_lz & (d != '0) & upper_zero[d];
    glyph = i_mode ? hex_glyph(nibs[d]) : hex_glyph({3'b000, disp_data[d]});
    seg_next    = blank ? 8'h00 : glyph;
    seg_next[0] = disp_dp[d];
    anodes_next = '1;
    if (lit) anodes_next[d] = 1'b0;
    else     seg_next = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_anodes   <= '1;
      o_segments <= 8'h00;
    end else begin
      o_anodes   <= anodes_next;
      o_segments <= seg_next;
    end
  end
endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter DWELL_W, default 14: per-digit dwell is 2^DWELL_W clk cycles; DWELL_W >= BRIGHT_W+1.
REQ-003 SHALL have parameter BRIGHT_W, default 3: width of brightness control.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_data, input, 4*N_DIGITS: value; nibble k drives digit k in hex mode; bit k drives digit k in binary mode.
REQ-007 SHALL have port i_dp, input, N_DIGITS: decimal point per digit, 1 = lit.
REQ-008 SHALL have port i_load, input, 1: one-cycle strobe that captures i_data and i_dp.
REQ-009 SHALL have port i_mode, input, 1: 0 = binary (glyph 0/1), 1 = hex (glyph 0-F).
REQ-010 SHALL have port i_blank_lz, input, 1: leading-zero blanking enable, hex mode only.
REQ-011 SHALL have port i_bright, input, BRIGHT_W: duty level; all ones = full on.
REQ-012 SHALL have port o_anodes, output, N_DIGITS: active-low digit enables.
REQ-013 SHALL have port o_segments, output, 8: active-high, bit 7..0 = a,b,c,d,e,f,g,dp.
REQ-014 SHALL have port o_frame, output, 1: one-cycle pulse at end of full scan.

Function
REQ-015 SHALL run dwell counter cnt (DWELL_W bits), incrementing every cycle and wrapping from max to 0.
REQ-016 SHALL hold digit index d, advancing when cnt==max; it SHALL wrap from N_DIGITS-1 to 0, i.e. d never reaches N_DIGITS.
REQ-017 SHALL assert o_frame for exactly one cycle in the cycle where d wraps from N_DIGITS-1 to 0.
REQ-018 On i_load, SHALL capture i_data/i_dp into a shadow register and set a pending flag.
REQ-019 At frame wrap with pending set, SHALL copy shadow to display register and clear pending; data change is therefore tear-free.
REQ-020 i_load coincident with frame wrap: SHALL load i_data/i_dp directly to display register; pending SHALL be left clear.
REQ-021 Repeated i_load before wrap: last capture SHALL win.
REQ-022 Glyphs SHALL be: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E (hex, dp bit clear); dp bit = display dp[d].
REQ-023 Binary mode: digit k SHALL show glyph 0 or 1 from display bit k; blanking SHALL be ignored.
REQ-024 Hex mode with i_blank_lz=1: digit k>0 SHALL be blanked (a-g = 0, dp still shown) when nibbles k..N_DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-025 Brightness: anode for d SHALL be enabled only while cnt[DWELL_W-1 -: BRIGHT_W] <= i_bright; otherwise all anodes SHALL be high and segments 00.
REQ-026 o_anodes and o_segments SHALL be registered, reflecting (d, cnt) of the previous cycle (1-cycle latency); exactly one anode low or none at any time.
REQ-027 i_mode, i_blank_lz, i_bright SHALL take effect combinationally on the next output register update (no latching).

Reset
REQ-028 On rst_n low, SHALL immediately clear cnt, d, pending, shadow, display register; o_anodes = all ones, o_segments = 00, o_frame = 0.
REQ-029 Reset asserted mid-frame or mid-load SHALL discard pending data; after release, scan SHALL restart at d=0, cnt=0 showing value 0.

Verification (N_DIGITS=4, DWELL_W=3, BRIGHT_W=2)
REQ-030 Reset release, i_mode=1, i_bright=3 -> o_anodes cycles E,D,B,7 every 8 clk, all glyphs FC; o_frame pulses every 32 clk.
REQ-031 i_load with i_data=0x1A3F, i_dp=0001 mid-frame -> old value until next o_frame; then digits 0..3 show 8F, F2, EE, 60.
REQ-032 i_data=0x0005, i_blank_lz=1 -> digit 0 shows B6; digits 1-3 segments 00 with anode low; i_blank_lz=0 -> FC on digits 1-3.
REQ-033 i_mode=0, i_data=0x000A -> digits 0..3 show FC, 60, FC, 60.
REQ-034 i_bright=0 -> each anode low for 2 of 8 dwell cycles, all high otherwise; i_bright=1 -> 4 of 8.
REQ-035 i_load on the o_frame cycle with 0x2222, then rst_n pulse mid-frame -> outputs all-off/00 during reset; after release, display shows 0 on all digits.
